axi_mig_slave_model: RTL



---
 rtl/axi_mig_slave_model.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mig_slave_model.sv
// ============================================================================
// axi_mig_slave_model
//
// AXI4 responder that stands in for the MIG DDR3 user interface. It accepts
// INCR bursts of 128-bit beats. The write channel (AW/W/B) and the read channel
// (AR/R) each run their own FSM, and each FSM holds one transaction at a time.
// Data is kept in a word-addressed array of DEPTH 128-bit words.
//
// Parameters
//   ADDR_W  AXI address width (both channels)
//   DEPTH   memory depth in 128-bit words, power of two
//   RD_LAT  cycles from AR handshake edge to first rvalid, 1..15
//
// Ports
//   ui_clk, ui_clk_sync_rst        clock, asynchronous active-high reset
//   s_axi_aw*                      write address/control + handshake
//   s_axi_w*                       write data beat + handshake
//   s_axi_b*                       write response
//   s_axi_ar*                      read address/control + handshake
//   s_axi_r*                       read data beat + handshake
//
// Word index is addr[4 +: log2(DEPTH)]. It increments per beat and wraps
// inside a burst. A request is legal only when size == 4 and burst == INCR.
// An illegal request still completes the full handshake and reports SLVERR.
// ============================================================================
module axi_mig_slave_model #(
    parameter int ADDR_W = 28,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 4
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,

    input  logic [3:0]        s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,

    input  logic [127:0]      s_axi_wdata,
    input  logic [15:0]       s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,

    output logic [3:0]        s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,

    input  logic [3:0]        s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,

    output logic [3:0]        s_axi_rid,
    output logic [127:0]      s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [127:0] mem [DEPTH];

    // Address bits outside the word index carry no meaning for this model.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_W-1:IDX_W+4], s_axi_awaddr[3:0],
                                s_axi_araddr[ADDR_W-1:IDX_W+4], s_axi_araddr[3:0]};

    // ------------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------------
    w_state_t         w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q;
    logic [7:0]       w_len_q, w_beat_q;
    logic             w_err_q;       // AW was illegal: discard data
    logic             w_last_err_q;  // sticky wlast protocol error
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [3:0]       bid_q;
    logic [1:0]       bresp_q;

    logic aw_hs, w_hs, b_hs, w_final, wlast_bad;
    assign aw_hs     = s_axi_awvalid & awready_q;
    assign w_hs      = s_axi_wvalid & wready_q;
    assign b_hs      = bvalid_q & s_axi_bready;
    assign w_final   = w_hs & (w_beat_q == w_len_q);
    assign wlast_bad = s_axi_wlast != (w_beat_q == w_len_q);

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) w_state_q <= W_IDLE;
        else                 w_state_q <= w_state_d;
    end

    // NOTE: every comb output gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs)   w_state_d = W_DATA;
            W_DATA:  if (w_final) w_state_d = W_RESP;
            W_RESP:  if (b_hs)    w_state_d = W_IDLE;
            default:              w_state_d = W_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state and registered below.
    // The registers sit at 0 in reset, so awready rises only on the first edge
    // after release.
    always_comb begin
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples pre-edge values regardless of statement order.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= RESP_OKAY;
            w_idx_q      <= '0;
            w_len_q      <= '0;
            w_beat_q     <= '0;
            w_err_q      <= 1'b0;
            w_last_err_q <= 1'b0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            if (aw_hs) begin
                bid_q        <= s_axi_awid;
                w_idx_q      <= s_axi_awaddr[4 +: IDX_W];
                w_len_q      <= s_axi_awlen;
                w_beat_q     <= '0;
                w_err_q      <= !((s_axi_awsize == 3'd4) && (s_axi_awburst == 2'b01));
                w_last_err_q <= 1'b0;
            end
            if (w_hs) begin
                w_idx_q      <= w_idx_q + IDX_W'(1);
                w_beat_q     <= w_beat_q + 8'd1;
                w_last_err_q <= w_last_err_q | wlast_bad;
            end
            // The final beat's own wlast check folds in directly.
            if (w_final) begin
                bresp_q <= (w_err_q | w_last_err_q | wlast_bad) ? RESP_SLV : RESP_OKAY;
            end
        end
    end

    // NOTE: the storage array has no reset on purpose. Contents survive reset,
    // and a reset branch would keep it from mapping onto RAM.
    always_ff @(posedge ui_clk) begin
        if (w_hs && !w_err_q) begin
            for (int b = 0; b < 16; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    r_state_t         r_state_q, r_state_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_nxt;
    logic [7:0]       r_len_q, r_beat_q;
    logic [3:0]       r_cnt_q;
    logic             r_err_q;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic             rlast_q;
    logic [3:0]       rid_q;
    logic [1:0]       rresp_q;
    logic [127:0]     rdata_q;

    logic ar_hs, r_hs, r_final, wait_done;
    assign ar_hs     = s_axi_arvalid & arready_q;
    assign r_hs      = rvalid_q & s_axi_rready;
    assign r_final   = r_hs & rlast_q;
    assign wait_done = (r_state_q == R_WAIT) && (r_cnt_q == 4'd0);
    assign r_idx_nxt = r_idx_q + IDX_W'(1);

    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) r_state_q <= R_IDLE;
        else                 r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)     r_state_d = R_WAIT;
            R_WAIT:  if (wait_done) r_state_d = R_DATA;
            R_DATA:  if (r_final)   r_state_d = R_IDLE;
            default:                r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // R_WAIT is entered with RD_LAT-1 and loads the first beat when the count
    // reaches zero. This puts rvalid exactly RD_LAT edges after the AR handshake.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            if (ar_hs) begin
                rid_q    <= s_axi_arid;
                r_idx_q  <= s_axi_araddr[4 +: IDX_W];
                r_len_q  <= s_axi_arlen;
                r_beat_q <= '0;
                r_cnt_q  <= WAIT_INIT;
                r_err_q  <= !((s_axi_arsize == 3'd4) && (s_axi_arburst == 2'b01));
            end
            if ((r_state_q == R_WAIT) && (r_cnt_q != 4'd0)) begin
                r_cnt_q <= r_cnt_q - 4'd1;
            end
            if (wait_done) begin
                rdata_q <= r_err_q ? '0 : mem[r_idx_q];
                rlast_q <= (r_len_q == 8'd0);
                rresp_q <= r_err_q ? RESP_SLV : RESP_OKAY;
            end
            // Beat registers change only on a handshake, so they stay stable
            // while the master stalls.
            if (r_hs && !rlast_q) begin
                r_idx_q  <= r_idx_nxt;
                r_beat_q <= r_beat_q + 8'd1;
                rdata_q  <= r_err_q ? '0 : mem[r_idx_nxt];
                rlast_q  <= ((r_beat_q + 8'd1) == r_len_q);
            end
            if (r_final) rlast_q <= 1'b0;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

endmodule
